// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
//   rsp_owner_e : which requester owns the read response due next cycle.
//   STREAK_W    : width of the consecutive-data-grant counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_D    = 2'd2
    } rsp_owner_e;

    localparam int STREAK_W = 4;

endpackage : mem_arb_pkg

// File: rtl/mem_arbiter_chk.sv
// Property checker for mem_arbiter, attached alongside the arbiter.
// Ports: clk, rst_n and the grant/response handshake signals.
//   - fetch and data are never granted together
//   - a read response only follows a read grant on the previous edge
module mem_arbiter_chk (
    input logic clk,
    input logic rst_n,
    input logic if_gnt,
    input logic d_gnt,
    input logic d_we,
    input logic if_rvalid,
    input logic d_rvalid
);

    a_one_grant: assert property (@(posedge clk) disable iff (!rst_n)
        !(if_gnt && d_gnt));

    a_if_rvalid_after_gnt: assert property (@(posedge clk) disable iff (!rst_n)
        if_rvalid |-> $past(if_gnt));

    a_d_rvalid_after_gnt: assert property (@(posedge clk) disable iff (!rst_n)
        d_rvalid |-> $past(d_gnt && !d_we));

endmodule : mem_arbiter_chk

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the instruction-fetch and data ports.
// At most one access is granted per cycle. Data has priority, except that
// fetch wins once data has been granted MAX_DATA_STREAK times in a row
// while fetch was waiting. Read responses (1-cycle latency) are routed back
// to the requester that issued them.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   if_req/if_addr                   fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata        fetch grant and read response
//   d_req/d_we/d_addr/d_wdata        data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata           data grant and read response
//   mem_en/mem_we/mem_addr/mem_wdata memory command (combinational)
//   mem_rdata                        memory read data, one cycle after read
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;
    rsp_owner_e          rsp_owner_q;
    rsp_owner_e          rsp_owner_d;
    logic                fetch_prio_s;
    logic                if_gnt_s;
    logic                d_gnt_s;

    // Fetch overrides data only when data has used up its streak budget.
    assign fetch_prio_s = if_req && (streak_q == STREAK_MAX);

    // Arbitration and memory command drive; nothing is granted during reset.
    always_comb begin
        if_gnt_s  = 1'b0;
        d_gnt_s   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {AW{1'b0}};
        mem_wdata = {DW{1'b0}};
        if (!rst_n) begin
            if_gnt_s = 1'b0;
            d_gnt_s  = 1'b0;
        end else if (d_req && !fetch_prio_s) begin
            d_gnt_s = 1'b1;
        end else if (if_req) begin
            if_gnt_s = 1'b1;
        end else begin
            if_gnt_s = 1'b0;
            d_gnt_s  = 1'b0;
        end

        if (d_gnt_s) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (if_gnt_s) begin
            mem_addr  = if_addr;
        end else begin
            mem_we    = 1'b0;
        end
    end

    // Next-state for the streak counter and the response owner.
    always_comb begin
        streak_d    = streak_q;
        rsp_owner_d = RSP_NONE;
        if (!if_req || if_gnt_s) begin
            streak_d = {STREAK_W{1'b0}};
        end else if (d_gnt_s && (streak_q != STREAK_MAX)) begin
            streak_d = streak_q + {{(STREAK_W-1){1'b0}}, 1'b1};
        end else begin
            streak_d = streak_q;
        end

        if (if_gnt_s) begin
            rsp_owner_d = RSP_IF;
        end else if (d_gnt_s && !d_we) begin
            rsp_owner_d = RSP_D;
        end else begin
            rsp_owner_d = RSP_NONE;
        end
    end

    // State register; reset drops any in-flight response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q    <= {STREAK_W{1'b0}};
            rsp_owner_q <= RSP_NONE;
        end else begin
            streak_q    <= streak_d;
            rsp_owner_q <= rsp_owner_d;
        end
    end

    assign if_gnt    = if_gnt_s;
    assign d_gnt     = d_gnt_s;
    assign mem_en    = if_gnt_s | d_gnt_s;
    assign if_rvalid = (rsp_owner_q == RSP_IF);
    assign d_rvalid  = (rsp_owner_q == RSP_D);
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed, scoreboard-based bench for mem_arbiter with a synchronous-read
// memory model behind it.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        preload;

    logic [31:0] mem_model [0:255];
    logic [31:0] ref_mem   [0:255];

    typedef struct packed {
        logic        is_if;
        logic [31:0] data;
    } rsp_t;

    rsp_t exp_q[$];
    int   total;
    int   bad;

    mem_arbiter #(.AW(32), .DW(32), .MAX_DATA_STREAK(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter_chk u_chk (
        .clk(clk), .rst_n(rst_n), .if_gnt(if_gnt), .d_gnt(d_gnt),
        .d_we(d_we), .if_rvalid(if_rvalid), .d_rvalid(d_rvalid)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous-read memory model with a preload strobe.
    always @(posedge clk) begin
        if (preload) begin
            mem_model[8'h04] <= 32'hDEADBEEF;
            mem_model[8'h10] <= 32'hCAFEF00D;
            mem_model[8'h00] <= 32'h11111111;
            mem_model[8'h01] <= 32'h22222222;
            mem_model[8'h20] <= 32'h00000000;
        end else if (mem_en && mem_we) begin
            mem_model[mem_addr[9:2]] <= mem_wdata;
        end else if (mem_en) begin
            mem_rdata <= mem_model[mem_addr[9:2]];
        end
    end

    task automatic chk(input string tag, input string what,
                       input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s.%s got=%h exp=%h", tag, what, obs, exp);
        end
    endtask

    // One cycle: check the response due now, the grant and memory command,
    // update the scoreboard, then advance to just after the rising edge.
    task automatic tick(input string tag, input logic e_if, input logic e_d);
        rsp_t        r;
        logic [31:0] e_addr;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            chk(tag, "if_rvalid", 32'(if_rvalid), 32'(r.is_if));
            chk(tag, "d_rvalid", 32'(d_rvalid), 32'(!r.is_if));
            chk(tag, "rdata", r.is_if ? if_rdata : d_rdata, r.data);
        end else begin
            chk(tag, "if_rvalid", 32'(if_rvalid), 32'd0);
            chk(tag, "d_rvalid", 32'(d_rvalid), 32'd0);
        end
        e_addr = e_d ? d_addr : (e_if ? if_addr : 32'd0);
        chk(tag, "if_gnt", 32'(if_gnt), 32'(e_if));
        chk(tag, "d_gnt", 32'(d_gnt), 32'(e_d));
        chk(tag, "mem_en", 32'(mem_en), 32'(e_if | e_d));
        chk(tag, "mem_we", 32'(mem_we), 32'(e_d & d_we));
        chk(tag, "mem_addr", mem_addr, e_addr);
        if (e_d || !e_if) begin
            chk(tag, "mem_wdata", mem_wdata, e_d ? d_wdata : 32'd0);
        end
        if (e_d && d_we) begin
            ref_mem[d_addr[9:2]] = d_wdata;
        end else if (e_d) begin
            exp_q.push_back({1'b0, ref_mem[d_addr[9:2]]});
        end else if (e_if) begin
            exp_q.push_back({1'b1, ref_mem[if_addr[9:2]]});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        ref_mem[8'h04] = 32'hDEADBEEF;
        ref_mem[8'h10] = 32'hCAFEF00D;
        ref_mem[8'h00] = 32'h11111111;
        ref_mem[8'h01] = 32'h22222222;
        ref_mem[8'h20] = 32'h00000000;
        rst_n   = 1'b1;
        preload = 1'b1;
        if_req  = 1'b1;
        if_addr = 32'h10;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h40;
        d_wdata = 32'h0;
        #2 rst_n = 1'b0;

        // Reset: requests pending but nothing granted or valid.
        @(negedge clk);
        chk("reset", "if_gnt", 32'(if_gnt), 32'd0);
        chk("reset", "d_gnt", 32'(d_gnt), 32'd0);
        chk("reset", "mem_en", 32'(mem_en), 32'd0);
        chk("reset", "mem_we", 32'(mem_we), 32'd0);
        chk("reset", "if_rvalid", 32'(if_rvalid), 32'd0);
        chk("reset", "d_rvalid", 32'(d_rvalid), 32'd0);
        @(posedge clk); #1;
        preload = 1'b0;
        if_req  = 1'b0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        rst_n   = 1'b1;
        tick("idle", 1'b0, 1'b0);

        // Fetch-only read.
        if_req = 1'b1; if_addr = 32'h10;
        tick("fetch", 1'b1, 1'b0);
        if_req = 1'b0;
        tick("fetch_rsp", 1'b0, 1'b0);

        // Simultaneous requests: data first, then fetch.
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        tick("simul", 1'b0, 1'b1);
        d_req = 1'b0;
        tick("simul_if", 1'b1, 1'b0);
        if_req = 1'b0;
        tick("simul_rsp", 1'b0, 1'b0);

        // Starvation guard: D,D,D,D,IF,D,D,D,D,IF.
        if_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick($sformatf("starve%0d", i), (i == 4) || (i == 9),
                 !((i == 4) || (i == 9)));
        end
        if_req = 1'b0; d_req = 1'b0;
        tick("starve_end", 1'b0, 1'b0);

        // Write then read back.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h12345678;
        tick("write", 1'b0, 1'b1);
        d_we = 1'b0; d_wdata = 32'h0;
        tick("readback", 1'b0, 1'b1);
        d_req = 1'b0;
        tick("readback_rsp", 1'b0, 1'b0);

        // Back-to-back reads: fetch 0x0 then data 0x4.
        if_req = 1'b1; if_addr = 32'h0;
        tick("b2b_if", 1'b1, 1'b0);
        if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
        tick("b2b_d", 1'b0, 1'b1);
        d_req = 1'b0;
        tick("b2b_rsp", 1'b0, 1'b0);

        // Reset during an outstanding fetch read.
        if_req = 1'b1; if_addr = 32'h10;
        tick("rst_fetch", 1'b1, 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_mid", "if_rvalid", 32'(if_rvalid), 32'd0);
        chk("rst_mid", "d_rvalid", 32'(d_rvalid), 32'd0);
        chk("rst_mid", "if_gnt", 32'(if_gnt), 32'd0);
        chk("rst_mid", "mem_en", 32'(mem_en), 32'd0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        if_req = 1'b0;
        tick("post_rst0", 1'b0, 1'b0);
        tick("post_rst1", 1'b0, 1'b0);
        if_req = 1'b1; if_addr = 32'h0;
        tick("post_rst_if", 1'b1, 1'b0);
        if_req = 1'b0;
        tick("post_rst_rsp", 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that shares one synchronous-read unified memory between the instruction-fetch port and the data-access port of the mips core. It sits between the core and the memory, in place of separate instruction and data memories. It grants at most one access per cycle and favours data accesses, with a bounded-starvation rule for fetch. It routes each read response back to the requester that issued it.

## Interface
- AW, 32, address width (byte address).
- DW, 32, data width.
- MAX_DATA_STREAK, 4, max consecutive data grants while fetch waits; legal 1..15.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  AW  fetch address; stable while if_req && !if_gnt.
- if_gnt  out  1  fetch accepted this cycle (combinational).
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DW  fetch read data.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  AW  data address.
- d_wdata  in  DW  write data.
- d_gnt  out  1  data access accepted this cycle (combinational).
- d_rvalid  out  1  data read data valid (reads only).
- d_rdata  out  DW  data read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid one cycle after mem_en && !mem_we.

## Operation
- Each cycle the arbiter selects at most one requester. The grant and the mem_* drive are combinational from the requests, the streak counter and rst_n.
- Default priority: data before fetch.
- The streak counter is 4 bits and starts at 0.
  - It increments on each data grant while if_req is high.
  - It clears on any fetch grant, or on any cycle with if_req low.
  - It saturates at MAX_DATA_STREAK.
- When streak == MAX_DATA_STREAK and if_req is high, fetch wins over a pending d_req for that cycle.
- The granted requester drives mem_addr (and mem_wdata/mem_we for data). mem_en = if_gnt | d_gnt.
- When nothing is granted:
  - mem_en = 0 and mem_we = 0.
  - mem_addr and mem_wdata hold 0.
- Response tracking uses a registered rsp_owner ∈ {RSP_NONE, RSP_IF, RSP_D}.
  - It is set on each edge from this cycle's grant: a fetch grant gives RSP_IF; a data read grant gives RSP_D; a write or no grant gives RSP_NONE.
  - if_rvalid = (rsp_owner == RSP_IF). d_rvalid = (rsp_owner == RSP_D).
  - if_rdata and d_rdata both equal mem_rdata; they are meaningful only while the matching rvalid is high.
- Writes complete on the grant edge and produce no rvalid.
- Requesters may issue back-to-back. A new grant may coincide with the rvalid of the previous access.

## Timing
- Reset values (asynchronous assert, synchronous-safe deassert):
  - rsp_owner = RSP_NONE, streak = 0.
  - While rst_n is low, all gnt, rvalid, mem_en and mem_we are 0.
- Grant latency is 0 cycles: gnt is asserted in the same cycle as req when the requester is selected.
- Read latency is exactly 1 cycle: rvalid is asserted the cycle after gnt.
- A requester that sees no gnt keeps req, addr and wdata stable. The arbiter does not store requests.
- Simultaneous if_req and d_req: data wins unless the streak has reached MAX_DATA_STREAK.
- Fetch starvation is bounded: with both requests high continuously, fetch is granted at least once every MAX_DATA_STREAK+1 cycles.
- Reset mid-operation drops any in-flight response; no rvalid appears after reset deassert until a new read is granted.

## Structure
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] rsp_owner_e {RSP_NONE, RSP_IF, RSP_D}.
  - localparam STREAK_W = 4.
- Single module, no sub-module: the arbitration is one always_comb block, and the streak counter and rsp_owner are one always_ff block.
- Assertions are included:
  - if_gnt and d_gnt are never both high.
  - rvalid is never high without a grant in the prior cycle.

## Test plan
- Fetch-only read: if_req=1, if_addr=0x10, memory[0x10]=0xDEADBEEF → if_gnt the same cycle; next cycle if_rvalid=1, if_rdata=0xDEADBEEF, d_rvalid=0.
- Simultaneous requests: if_req=d_req=1 (d read 0x40) in one cycle → d_gnt=1, if_gnt=0; next cycle d_rvalid=1, and fetch is granted if still requesting.
- Starvation guard: MAX_DATA_STREAK=4, both requests held high for 10 cycles → grant pattern D,D,D,D,IF,D,D,D,D,IF.
- Write: d_req=1, d_we=1, d_addr=0x80, d_wdata=0x12345678 → mem_we=1 for one cycle, d_rvalid stays 0; a following read of 0x80 returns 0x12345678.
- Back-to-back reads: fetch 0x0 then data 0x4 on consecutive cycles → rvalids arrive one per cycle, routed to IF then D with the correct data.
- Reset mid-read: assert rst_n=0 in the cycle after a fetch grant → if_rvalid is forced to 0; after release, all outputs are 0 until a new request.
